// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/timing constants.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned MIN_DIV     = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; flops reset to the line idle level.
module uart_sync #(
  parameter int unsigned STAGES  = uart_pkg::SYNC_STAGES,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling, LSB-first payload, frame-error/break handling and a one-deep holding register.
module uart_rx_core #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS,
  parameter int unsigned MIN_DIV   = uart_pkg::MIN_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic                  rxs;
  logic [CNT_W-1:0]      div_eff_c;
  logic                  tick_c;
  logic                  last_bit_c;
  logic                  done_c;
  logic                  ferr_c;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  assign div_eff_c  = (baud_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : baud_div;
  assign tick_c     = (cnt_q == '0);
  assign last_bit_c = (bit_q == BIT_W'(DATA_BITS - 1));
  assign done_c     = (state_q == ST_STOP) && tick_c && rxs;
  assign ferr_c     = (state_q == ST_STOP) && tick_c && !rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!rxs) state_d = ST_START;
      ST_START: if (tick_c) state_d = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick_c && last_bit_c) state_d = ST_STOP;
      ST_STOP:  if (tick_c) state_d = rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit timing: down-counter reloaded at every sample point, so it never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          div_d = div_eff_c;
          cnt_d = (div_eff_c >> 1) - CNT_W'(1);
          bit_d = '0;
        end
      end
      ST_START, ST_STOP: begin
        cnt_d = tick_c ? div_q - CNT_W'(1) : cnt_q - CNT_W'(1);
        if (tick_c && state_q == ST_STOP) cnt_d = '0;
      end
      ST_DATA: begin
        if (tick_c) begin
          cnt_d   = div_q - CNT_W'(1);
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BREAK: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = ferr_c;
    busy_d      = (state_d != ST_IDLE);
    if (done_c) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
      else if (rx_valid_q)       overrun_d = 1'b0;
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core: frames, glitch, break, overrun, clamp and reset cases.
module tb_uart_rx_core;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int n_checks;
  int n_fail;
  int ferr_pulses;

  uart_rx_core dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ferr_pulses = 0;
  always @(posedge clk) if (frame_err) ferr_pulses = ferr_pulses + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame at 'div' clocks per bit; baud_div is switched to new_div after the start bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int div,
                           input logic [15:0] new_div);
    rx = 1'b0;
    wait_clks(div);
    baud_div = new_div;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(div);
    end
    rx = stop_bit;
    wait_clks(div);
    rx = 1'b1;
  endtask

  task automatic ack_pulse;
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
    wait_clks(1);
  endtask

  int ferr_base;
  int waited;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ack   = 1'b0;
    baud_div = 16'd434;
    wait_clks(3);
    check_eq("rst_data", 32'(rx_data), 32'h0);
    check_eq("rst_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_ovr", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clks(5);

    // Clean frame 0xA5 at 434
    ferr_base = ferr_pulses;
    send_byte(8'hA5, 1'b1, 434, 16'd434);
    wait_clks(4);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_valid", 32'(rx_valid), 32'h1);
    check_eq("a5_ferr", 32'(ferr_pulses - ferr_base), 32'h0);
    check_eq("a5_ovr", 32'(overrun), 32'h0);
    check_eq("a5_busy", 32'(busy), 32'h0);
    ack_pulse();
    check_eq("a5_ack_valid", 32'(rx_valid), 32'h0);

    // 100-clock low glitch is rejected in START
    rx = 1'b0;
    wait_clks(100);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 220) begin
      wait_clks(1);
      waited++;
    end
    check_eq("glitch_busy", 32'(busy), 32'h0);
    check_eq("glitch_valid", 32'(rx_valid), 32'h0);
    wait_clks(10);

    // 0x3C with low stop bit followed by a long break
    ferr_base = ferr_pulses;
    send_byte(8'h3C, 1'b0, 434, 16'd434);
    rx = 1'b0;
    wait_clks(2000);
    check_eq("brk_ferr_cnt", 32'(ferr_pulses - ferr_base), 32'h1);
    check_eq("brk_valid", 32'(rx_valid), 32'h0);
    check_eq("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clks(5);
    check_eq("brk_busy_rel", 32'(busy), 32'h0);
    check_eq("brk_ferr_total", 32'(ferr_pulses - ferr_base), 32'h1);

    // Back-to-back without ack: overrun
    send_byte(8'h11, 1'b1, 434, 16'd434);
    wait_clks(4);
    check_eq("ov1_data", 32'(rx_data), 32'h11);
    check_eq("ov1_ovr", 32'(overrun), 32'h0);
    send_byte(8'h22, 1'b1, 434, 16'd434);
    wait_clks(4);
    check_eq("ov2_data", 32'(rx_data), 32'h22);
    check_eq("ov2_valid", 32'(rx_valid), 32'h1);
    check_eq("ov2_ovr", 32'(overrun), 32'h1);
    ack_pulse();
    check_eq("ov_ack_valid", 32'(rx_valid), 32'h0);
    check_eq("ov_ack_ovr", 32'(overrun), 32'h0);
    ack_pulse();
    check_eq("idle_ack_valid", 32'(rx_valid), 32'h0);
    check_eq("idle_ack_ovr", 32'(overrun), 32'h0);
    check_eq("idle_ack_data", 32'(rx_data), 32'h22);

    // Divisor below minimum is clamped to 16
    baud_div = 16'd5;
    send_byte(8'h81, 1'b1, 16, 16'd5);
    wait_clks(4);
    check_eq("clamp_data", 32'(rx_data), 32'h81);
    check_eq("clamp_valid", 32'(rx_valid), 32'h1);
    ack_pulse();

    // Divisor change mid-frame is ignored
    baud_div = 16'd434;
    ferr_base = ferr_pulses;
    send_byte(8'h5A, 1'b1, 434, 16'd868);
    wait_clks(4);
    check_eq("chg_data", 32'(rx_data), 32'h5A);
    check_eq("chg_valid", 32'(rx_valid), 32'h1);
    check_eq("chg_ferr", 32'(ferr_pulses - ferr_base), 32'h0);
    ack_pulse();

    // Reset mid-frame abandons it; next frame is received normally
    baud_div = 16'd16;
    rx = 1'b0;
    wait_clks(16 * 4);
    rx  = 1'b1;
    rst = 1'b1;
    wait_clks(2);
    check_eq("mrst_busy", 32'(busy), 32'h0);
    check_eq("mrst_valid", 32'(rx_valid), 32'h0);
    check_eq("mrst_data", 32'(rx_data), 32'h0);
    rst = 1'b0;
    wait_clks(20);
    check_eq("mrst_idle_busy", 32'(busy), 32'h0);
    send_byte(8'h96, 1'b1, 16, 16'd16);
    wait_clks(4);
    check_eq("mrst_rx_data", 32'(rx_data), 32'h96);
    check_eq("mrst_rx_valid", 32'(rx_valid), 32'h1);
    check_eq("mrst_rx_ovr", 32'(overrun), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
